// File: rtl/scan_test_sequencer.sv
// Scan test sequencer: fetches patterns, shifts them into a full-scan chain,
// captures, unloads and compacts all responses into a 16-bit MISR.
module scan_test_sequencer #(
    parameter int CHAIN_LEN = 21,
    parameter int NUM_PI    = 3,
    parameter int NUM_PO    = 6,
    parameter int CNT_W     = 16
) (
    input  logic                        CK,
    input  logic                        RSTN,
    input  logic                        start,
    input  logic                        abort,
    input  logic [CNT_W-1:0]            num_patterns,
    input  logic                        pat_valid,
    output logic                        pat_ready,
    input  logic [CHAIN_LEN+NUM_PI-1:0] pat_data,
    output logic                        scan_en,
    output logic                        scan_in,
    input  logic                        scan_out,
    output logic [NUM_PI-1:0]           pi_out,
    input  logic [NUM_PO-1:0]           po_in,
    output logic                        busy,
    output logic                        done,
    output logic                        sig_valid,
    output logic [15:0]                 signature
);

    localparam int BW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(CHAIN_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_CAPTURE,
        S_UNLOAD,
        S_DONE
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     npat_q, npat_d;
    logic [CNT_W-1:0]     idx_q, idx_d;
    logic [CNT_W-1:0]     idx_inc;
    logic [BW-1:0]        cnt_q, cnt_d;
    logic [CHAIN_LEN-1:0] shreg_q, shreg_d;
    logic [NUM_PI-1:0]    pi_q, pi_d;
    logic [15:0]          misr_q, misr_d;
    logic                 sig_valid_q, sig_valid_d;

    logic                 start_acc;
    logic                 pat_acc;
    logic                 last_bit;

    function automatic logic [15:0] misr_next(input logic [15:0] m,
                                              input logic [15:0] d);
        return (m << 1) ^ (m[15] ? 16'h1021 : 16'h0000) ^ d;
    endfunction

    assign idx_inc  = idx_q + CNT_W'(1);
    assign last_bit = (cnt_q == LAST_BIT);

    // State register
    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort wins over everything outside IDLE
    always_comb begin
        state_d = state_q;
        if (state_q != S_IDLE && abort) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        state_d = (num_patterns == '0) ? S_DONE : S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (pat_valid) state_d = S_SHIFT;
                end
                S_SHIFT: begin
                    if (last_bit) state_d = S_CAPTURE;
                end
                S_CAPTURE: begin
                    state_d = (idx_inc == npat_q) ? S_UNLOAD : S_LOAD;
                end
                S_UNLOAD: begin
                    if (last_bit) state_d = S_DONE;
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output decode; chain-facing strobes drop in the abort cycle itself
    always_comb begin
        pat_ready = (state_q == S_LOAD) && !abort;
        scan_en   = (state_q == S_SHIFT || state_q == S_UNLOAD) && !abort;
        scan_in   = (state_q == S_SHIFT) && !abort && shreg_q[0];
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE) && !abort;
        pi_out    = pi_q;
        sig_valid = sig_valid_q;
        signature = misr_q;
    end

    // Datapath next values: pattern latch, shift, counters and MISR
    always_comb begin
        start_acc   = (state_q == S_IDLE) && start && !abort;
        pat_acc     = pat_ready && pat_valid;
        npat_d      = npat_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        pi_d        = pi_q;
        misr_d      = misr_q;
        sig_valid_d = sig_valid_q;

        if (start_acc) begin
            npat_d      = num_patterns;
            idx_d       = '0;
            misr_d      = '0;
            sig_valid_d = 1'b0;
        end

        if (pat_acc) begin
            shreg_d = pat_data[CHAIN_LEN-1:0];
            pi_d    = pat_data[CHAIN_LEN +: NUM_PI];
            cnt_d   = '0;
        end

        if (!abort) begin
            unique case (state_q)
                S_SHIFT: begin
                    shreg_d = {1'b0, shreg_q[CHAIN_LEN-1:1]};
                    cnt_d   = cnt_q + BW'(1);
                    if (idx_q != '0) begin
                        misr_d = misr_next(misr_q, 16'(scan_out));
                    end
                end
                S_CAPTURE: begin
                    misr_d = misr_next(misr_q, 16'(po_in));
                    idx_d  = idx_inc;
                    cnt_d  = '0;
                end
                S_UNLOAD: begin
                    misr_d = misr_next(misr_q, 16'(scan_out));
                    cnt_d  = cnt_q + BW'(1);
                end
                default: ;
            endcase
        end

        if (state_d == S_DONE && state_q != S_DONE) begin
            sig_valid_d = 1'b1;
        end
    end

    // Datapath registers
    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            npat_q      <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            shreg_q     <= '0;
            pi_q        <= '0;
            misr_q      <= '0;
            sig_valid_q <= 1'b0;
        end else begin
            npat_q      <= npat_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            pi_q        <= pi_d;
            misr_q      <= misr_d;
            sig_valid_q <= sig_valid_d;
        end
    end

endmodule

// File: doc/scan_test_sequencer.md
Name: scan_test_sequencer

Overview:
- Sequences scan-based test of a sequential benchmark core: full-scan chain of CHAIN_LEN D-flops, NUM_PI primary inputs, NUM_PO primary outputs.
- Fetches patterns over a valid/ready handshake, shifts each into the chain, applies PIs, issues one capture cycle, and unloads responses.
- Compacts all responses into a 16-bit MISR signature.
- Sits between the pattern source (ATPG vector memory or testbench) and the scan-inserted core.

Parameters:
- CHAIN_LEN, 21, number of scan flops in the chain.
- NUM_PI, 3, number of core primary inputs driven during capture.
- NUM_PO, 6, number of core primary outputs sampled at capture; must be ≤ 16.
- CNT_W, 16, width of the pattern count and index.

Ports:
- CK  in  1  clock, rising edge.
- RSTN  in  1  asynchronous active-low reset.
- start  in  1  begin a test session; sampled only in IDLE.
- abort  in  1  synchronous abort of the session.
- num_patterns  in  CNT_W  number of patterns; sampled when start is accepted.
- pat_valid  in  1  pattern word valid.
- pat_ready  out  1  sequencer accepts a pattern word.
- pat_data  in  CHAIN_LEN+NUM_PI  pattern word; [CHAIN_LEN-1:0] are chain bits, upper NUM_PI bits are PI values.
- scan_en  out  1  scan-enable to the core chain.
- scan_in  out  1  serial data to the chain head.
- scan_out  in  1  serial data from the chain tail.
- pi_out  out  NUM_PI  core primary inputs.
- po_in  in  NUM_PO  core primary outputs.
- busy  out  1  session in progress.
- done  out  1  one-cycle pulse at session end.
- sig_valid  out  1  signature final; held until the next start is accepted.
- signature  out  16  MISR contents.

Behaviour:
Reset
- RSTN low forces state IDLE immediately.
- All outputs go 0: scan_en, scan_in, pi_out, pat_ready, busy, done, sig_valid, signature=0x0000.
- Internal pattern index, bit counter and shift register clear.

States: IDLE, LOAD, SHIFT, CAPTURE, UNLOAD, DONE.

IDLE
- busy=0.
- start=1 clears the MISR and sig_valid and latches num_patterns.
- If num_patterns=0, go to DONE; otherwise go to LOAD.

LOAD
- pat_ready=1, scan_en=0.
- On pat_valid&pat_ready: latch the chain bits into the shift register, latch the PI bits into pi_out, clear the bit counter, go to SHIFT.
- pat_valid low: remain in LOAD indefinitely.

SHIFT
- Lasts exactly CHAIN_LEN cycles with scan_en=1 and scan_in=shreg[0], LSB first; the shift register shifts right each cycle.
- MISR absorbs scan_out each cycle, except during pattern index 0, where the unload is uninitialised and masked.
- After the last shift, go to CAPTURE.

CAPTURE
- Exactly 1 cycle with scan_en=0 and pi_out stable (held since LOAD).
- MISR absorbs po_in, zero-extended to 16 bits.
- Pattern index increments.
- If the index equals num_patterns, go to UNLOAD; otherwise go to LOAD.

UNLOAD
- CHAIN_LEN cycles with scan_en=1, scan_in=0; MISR absorbs scan_out each cycle.
- Then go to DONE.

DONE
- done=1 for one cycle and sig_valid becomes 1; go to IDLE.
- busy=1 in every state except IDLE.

MISR update
- next = (m<<1) ^ (m[15] ? 16'h1021 : 0) ^ d, where d is zero-extended.
- Updates only in the absorbing cycles listed above; otherwise holds.
- signature always reflects m.

Timing
- With pat_valid held high and N≥1, done is high in cycle 23N+22 after the start-accept edge, for CHAIN_LEN=21.
- In general: 1 + N·(CHAIN_LEN+2) + CHAIN_LEN.

abort
- Any non-IDLE state goes to IDLE next cycle.
- scan_en=0, pat_ready=0; no done pulse; sig_valid stays 0.
- The signature keeps its partial value until the next start.
- abort in IDLE is ignored; abort has priority over start.

Other boundaries
- start while busy is ignored.
- A pattern word offered outside LOAD is not accepted.
- num_patterns is maximum 2^CNT_W−1; the index never wraps within a session.

Test Plan:
- num_patterns=0, pulse start → done high on cycle 1 after start, busy high only in that cycle, sig_valid=1, signature=0x0000.
- N=1, pat_data chain bits=21'h000001, PI=3'b101, scan_out=0, po_in=0 → scan_in=1 only on the first SHIFT cycle; pi_out=3'b101 during CAPTURE; done at cycle 45; signature=0x0000.
- Same as above but po_in=6'b000001 at capture, scan_out=0 → signature=0x2462.
- N=2, pat_valid withheld for 5 cycles before the second pattern → pat_ready high throughout the wait, scan_en=0, MISR unchanged; done at cycle 68+5.
- Assert abort in the 10th SHIFT cycle of pattern 0 → next cycle IDLE, scan_en=0, no done pulse, sig_valid=0; a fresh start then runs normally.
- Drop RSTN mid-UNLOAD → outputs 0 asynchronously, before the next CK edge; after release the block is in IDLE with signature=0x0000.
